// File: rtl/tweak_alu_pipe_if.sv
// Operand/result handshake bundle between the register-read stage, the pipelined ALU
// and writeback. The slave modport is the ALU side; the master modport is the producer/consumer side.
interface tweak_alu_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [5:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAGW-1:0]  in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;
    logic [TAGW-1:0]  out_tag;

    modport slave (
        input  in_valid, in_opcode, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_flags, out_tag
    );

    modport master (
        output in_valid, in_opcode, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_flags, out_tag
    );
endinterface

// File: rtl/tweak_alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 registers the operands, and S2 registers the
// result, the {N,Z,C,V} flags and the tag. Flush is synchronous; NRES is an async active-low reset.
module tweak_alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAGW  = 4
) (
    input  logic            CLK,
    input  logic            NRES,
    input  logic            flush_i,
    output logic            busy_o,
    tweak_alu_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_AND  = 6'd2;
    localparam logic [5:0] OP_OR   = 6'd3;
    localparam logic [5:0] OP_XOR  = 6'd4;
    localparam logic [5:0] OP_SHL  = 6'd5;
    localparam logic [5:0] OP_SHR  = 6'd6;
    localparam logic [5:0] OP_SAR  = 6'd7;
    localparam logic [5:0] OP_SLT  = 6'd8;
    localparam logic [5:0] OP_SLTU = 6'd9;

    logic             s1_v_q,   s1_v_d;
    logic [5:0]       s1_op_q,  s1_op_d;
    logic [WIDTH-1:0] s1_a_q,   s1_a_d;
    logic [WIDTH-1:0] s1_b_q,   s1_b_d;
    logic [TAGW-1:0]  s1_tag_q, s1_tag_d;

    logic             s2_v_q,   s2_v_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic [3:0]       s2_fl_q,  s2_fl_d;
    logic [TAGW-1:0]  s2_tag_q, s2_tag_d;

    logic             s2_adv;
    logic             accept;
    logic             consume;

    logic [SHW-1:0]   sh_amt;
    logic [WIDTH:0]   wide;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    assign s2_adv       = s1_v_q & (~s2_v_q | bus.out_ready);
    assign bus.in_ready = ~flush_i & (~s1_v_q | s2_adv);
    assign accept       = bus.in_valid & bus.in_ready;
    assign consume      = s2_v_q & bus.out_ready;

    assign bus.out_valid  = s2_v_q;
    assign bus.out_result = s2_res_q;
    assign bus.out_flags  = s2_fl_q;
    assign bus.out_tag    = s2_tag_q;
    assign busy_o         = s1_v_q | s2_v_q;

    assign sh_amt = s1_b_q[SHW-1:0];

    // Shifts run one bit wider than the operand so the last bit shifted out lands in wide[WIDTH] or wide[0].
    always_comb begin
        wide    = '0;
        alu_res = s1_a_q;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (s1_op_q)
            OP_ADD: begin
                wide    = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (s1_a_q[WIDTH-1] == s1_b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_SUB: begin
                wide    = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != s1_a_q[WIDTH-1]);
            end
            OP_AND: alu_res = s1_a_q & s1_b_q;
            OP_OR:  alu_res = s1_a_q | s1_b_q;
            OP_XOR: alu_res = s1_a_q ^ s1_b_q;
            OP_SHL: begin
                wide    = {1'b0, s1_a_q} << sh_amt;
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
            end
            OP_SHR: begin
                wide    = {s1_a_q, 1'b0} >> sh_amt;
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_SAR: begin
                wide    = $unsigned($signed({s1_a_q, 1'b0}) >>> sh_amt);
                alu_res = wide[WIDTH:1];
                alu_c   = wide[0];
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a_q) < $signed(s1_b_q))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (s1_a_q < s1_b_q)};
            default: alu_res = s1_a_q;
        endcase
    end

    always_comb begin
        s1_v_d   = s1_v_q;
        s1_op_d  = s1_op_q;
        s1_a_d   = s1_a_q;
        s1_b_d   = s1_b_q;
        s1_tag_d = s1_tag_q;
        if (flush_i) begin
            s1_v_d = 1'b0;
        end else if (accept) begin
            s1_v_d   = 1'b1;
            s1_op_d  = bus.in_opcode;
            s1_a_d   = bus.in_a;
            s1_b_d   = bus.in_b;
            s1_tag_d = bus.in_tag;
        end else if (s2_adv) begin
            s1_v_d = 1'b0;
        end
    end

    always_comb begin
        s2_v_d   = s2_v_q;
        s2_res_d = s2_res_q;
        s2_fl_d  = s2_fl_q;
        s2_tag_d = s2_tag_q;
        if (flush_i) begin
            s2_v_d = 1'b0;
        end else if (s2_adv) begin
            s2_v_d   = 1'b1;
            s2_res_d = alu_res;
            s2_fl_d  = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            s2_tag_d = s1_tag_q;
        end else if (consume) begin
            s2_v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge NRES) begin
        if (!NRES) begin
            s1_v_q   <= 1'b0;
            s1_op_q  <= '0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_tag_q <= '0;
            s2_v_q   <= 1'b0;
            s2_res_q <= '0;
            s2_fl_q  <= '0;
            s2_tag_q <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_op_q  <= s1_op_d;
            s1_a_q   <= s1_a_d;
            s1_b_q   <= s1_b_d;
            s1_tag_q <= s1_tag_d;
            s2_v_q   <= s2_v_d;
            s2_res_q <= s2_res_d;
            s2_fl_q  <= s2_fl_d;
            s2_tag_q <= s2_tag_d;
        end
    end
endmodule

// File: tb/tb_tweak_alu_pipe.sv
// Directed bench for tweak_alu_pipe: a 32-bit instance for opcodes, backpressure, flush
// and reset, plus an 8-bit instance for narrow-width flag behaviour.
module tb_tweak_alu_pipe;
    logic CLK = 1'b0;
    logic NRES = 1'b1;
    logic flush32 = 1'b0;
    logic flush8 = 1'b0;
    logic busy32;
    logic busy8;
    int n_checks = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    tweak_alu_pipe_if #(.WIDTH(32), .TAGW(4)) bus32 ();
    tweak_alu_pipe_if #(.WIDTH(8),  .TAGW(4)) bus8 ();

    tweak_alu_pipe #(.WIDTH(32), .TAGW(4)) u_dut32 (
        .CLK(CLK), .NRES(NRES), .flush_i(flush32), .busy_o(busy32), .bus(bus32.slave));
    tweak_alu_pipe #(.WIDTH(8), .TAGW(4)) u_dut8 (
        .CLK(CLK), .NRES(NRES), .flush_i(flush8), .busy_o(busy8), .bus(bus8.slave));

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    task automatic drive32(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
        bus32.in_valid  = 1'b1;
        bus32.in_opcode = op;
        bus32.in_a      = a;
        bus32.in_b      = b;
        bus32.in_tag    = tag;
    endtask

    task automatic test_reset();
        bus32.in_valid = 1'b0; bus32.in_opcode = '0; bus32.in_a = '0; bus32.in_b = '0;
        bus32.in_tag = '0; bus32.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_opcode = '0; bus8.in_a = '0; bus8.in_b = '0;
        bus8.in_tag = '0; bus8.out_ready = 1'b1;
        #2 NRES = 1'b0;
        #1;
        n_checks++; if (bus32.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus32.out_valid); else n_pass++;
        n_checks++; if (busy32 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy32); else n_pass++;
        n_checks++; if (bus32.out_result !== 32'h0) $display("FAIL reset_result: got %h want 0", bus32.out_result); else n_pass++;
        n_checks++; if (bus32.out_flags !== 4'h0) $display("FAIL reset_flags: got %b want 0000", bus32.out_flags); else n_pass++;
        n_checks++; if (bus32.out_tag !== 4'h0) $display("FAIL reset_tag: got %h want 0", bus32.out_tag); else n_pass++;
        @(negedge CLK);
        @(negedge CLK);
        NRES = 1'b1;
        #1;
        n_checks++; if (bus32.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus32.in_ready); else n_pass++;
    endtask

    task automatic test_ops();
        vec_t v[13];
        // {op, a, b, tag, expected result, expected {N,Z,C,V}}
        v[0]  = {6'd0,  32'hFFFF_FFFF, 32'h0000_0001, 4'd3,  32'h0000_0000, 4'b0110};
        v[1]  = {6'd1,  32'h8000_0000, 32'h0000_0001, 4'd1,  32'h7FFF_FFFF, 4'b0001};
        v[2]  = {6'd1,  32'h0000_0001, 32'h0000_0002, 4'd2,  32'hFFFF_FFFF, 4'b1010};
        v[3]  = {6'd7,  32'h8000_0000, 32'h0000_0004, 4'd4,  32'hF800_0000, 4'b1000};
        v[4]  = {6'd5,  32'h8000_0001, 32'h0000_0021, 4'd5,  32'h0000_0002, 4'b0010};
        v[5]  = {6'h3F, 32'h0000_1234, 32'h0000_0005, 4'd6,  32'h0000_1234, 4'b0000};
        v[6]  = {6'd6,  32'h0000_0003, 32'h0000_0001, 4'd7,  32'h0000_0001, 4'b0010};
        v[7]  = {6'd6,  32'h0000_000F, 32'h0000_0020, 4'd8,  32'h0000_000F, 4'b0000};
        v[8]  = {6'd8,  32'hFFFF_FFFF, 32'h0000_0001, 4'd9,  32'h0000_0001, 4'b0000};
        v[9]  = {6'd9,  32'hFFFF_FFFF, 32'h0000_0001, 4'd10, 32'h0000_0000, 4'b0100};
        v[10] = {6'd2,  32'h0000_F0F0, 32'h0000_FF00, 4'd11, 32'h0000_F000, 4'b0000};
        v[11] = {6'd3,  32'h8000_0000, 32'h0000_0001, 4'd12, 32'h8000_0001, 4'b1000};
        v[12] = {6'd4,  32'h0000_0005, 32'h0000_0005, 4'd13, 32'h0000_0000, 4'b0100};
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            drive32(v[i].op, v[i].a, v[i].b, v[i].tag);
            #1;
            n_checks++; if (bus32.in_ready !== 1'b1) $display("FAIL op%0d_in_ready: got %b want 1", i, bus32.in_ready); else n_pass++;
            @(negedge CLK);
            bus32.in_valid = 1'b0;
            n_checks++; if (bus32.out_valid !== 1'b0) $display("FAIL op%0d_early_valid: got %b want 0", i, bus32.out_valid); else n_pass++;
            @(negedge CLK);
            n_checks++; if (bus32.out_valid !== 1'b1) $display("FAIL op%0d_valid: got %b want 1", i, bus32.out_valid); else n_pass++;
            n_checks++; if (bus32.out_result !== v[i].res) $display("FAIL op%0d_result: got %h want %h", i, bus32.out_result, v[i].res); else n_pass++;
            n_checks++; if (bus32.out_flags !== v[i].fl) $display("FAIL op%0d_flags: got %b want %b", i, bus32.out_flags, v[i].fl); else n_pass++;
            n_checks++; if (bus32.out_tag !== v[i].tag) $display("FAIL op%0d_tag: got %h want %h", i, bus32.out_tag, v[i].tag); else n_pass++;
        end
        @(negedge CLK);
        n_checks++; if (busy32 !== 1'b0) $display("FAIL ops_drained_busy: got %b want 0", busy32); else n_pass++;
    endtask

    task automatic test_backpressure();
        bus32.out_ready = 1'b0;
        @(negedge CLK);
        drive32(6'd0, 32'd1, 32'd0, 4'd1);
        #1;
        n_checks++; if (bus32.in_ready !== 1'b1) $display("FAIL bp_ready_t1: got %b want 1", bus32.in_ready); else n_pass++;
        @(negedge CLK);
        drive32(6'd0, 32'd2, 32'd0, 4'd2);
        #1;
        n_checks++; if (bus32.in_ready !== 1'b1) $display("FAIL bp_ready_t2: got %b want 1", bus32.in_ready); else n_pass++;
        @(negedge CLK);
        drive32(6'd0, 32'd3, 32'd0, 4'd3);
        #1;
        n_checks++; if (bus32.in_ready !== 1'b0) $display("FAIL bp_ready_full: got %b want 0", bus32.in_ready); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            n_checks++; if (bus32.out_valid !== 1'b1) $display("FAIL bp_hold%0d_valid: got %b want 1", i, bus32.out_valid); else n_pass++;
            n_checks++; if (bus32.out_tag !== 4'd1) $display("FAIL bp_hold%0d_tag: got %h want 1", i, bus32.out_tag); else n_pass++;
            n_checks++; if (bus32.out_result !== 32'd1) $display("FAIL bp_hold%0d_result: got %h want 1", i, bus32.out_result); else n_pass++;
            n_checks++; if (bus32.in_ready !== 1'b0) $display("FAIL bp_hold%0d_ready: got %b want 0", i, bus32.in_ready); else n_pass++;
        end
        @(negedge CLK);
        bus32.out_ready = 1'b1;
        #1;
        n_checks++; if (bus32.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", bus32.in_ready); else n_pass++;
        n_checks++; if (bus32.out_tag !== 4'd1) $display("FAIL bp_deliver1: got %h want 1", bus32.out_tag); else n_pass++;
        @(negedge CLK);
        bus32.in_valid = 1'b0;
        n_checks++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 4'd2) $display("FAIL bp_deliver2: got v=%b tag=%h want v=1 tag=2", bus32.out_valid, bus32.out_tag); else n_pass++;
        @(negedge CLK);
        n_checks++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 4'd3 || bus32.out_result !== 32'd3) $display("FAIL bp_deliver3: got v=%b tag=%h res=%h want v=1 tag=3 res=3", bus32.out_valid, bus32.out_tag, bus32.out_result); else n_pass++;
        @(negedge CLK);
        n_checks++; if (bus32.out_valid !== 1'b0 || busy32 !== 1'b0) $display("FAIL bp_empty: got v=%b busy=%b want 0 0", bus32.out_valid, busy32); else n_pass++;
    endtask

    task automatic test_flush();
        bus32.out_ready = 1'b0;
        @(negedge CLK);
        drive32(6'd0, 32'd5, 32'd0, 4'd5);
        @(negedge CLK);
        drive32(6'd0, 32'd6, 32'd0, 4'd6);
        @(negedge CLK);
        n_checks++; if (busy32 !== 1'b1 || bus32.out_valid !== 1'b1) $display("FAIL flush_full: got busy=%b v=%b want 1 1", busy32, bus32.out_valid); else n_pass++;
        flush32 = 1'b1;
        drive32(6'd0, 32'd9, 32'd0, 4'd9);
        #1;
        n_checks++; if (bus32.in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", bus32.in_ready); else n_pass++;
        @(negedge CLK);
        flush32 = 1'b0;
        bus32.in_valid = 1'b0;
        bus32.out_ready = 1'b1;
        n_checks++; if (bus32.out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b want 0", bus32.out_valid); else n_pass++;
        n_checks++; if (busy32 !== 1'b0) $display("FAIL flush_busy: got %b want 0", busy32); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            n_checks++; if (bus32.out_valid !== 1'b0) $display("FAIL flush_ghost%0d: got v=%b tag=%h want v=0", i, bus32.out_valid, bus32.out_tag); else n_pass++;
        end
        drive32(6'd0, 32'd1, 32'd1, 4'd10);
        @(negedge CLK);
        bus32.in_valid = 1'b0;
        @(negedge CLK);
        n_checks++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 4'd10 || bus32.out_result !== 32'd2) $display("FAIL flush_after: got v=%b tag=%h res=%h want v=1 tag=a res=2", bus32.out_valid, bus32.out_tag, bus32.out_result); else n_pass++;
        @(negedge CLK);
    endtask

    task automatic test_reset_midstream();
        bus32.out_ready = 1'b0;
        @(negedge CLK);
        drive32(6'd0, 32'd7, 32'd0, 4'd7);
        @(negedge CLK);
        drive32(6'd0, 32'd8, 32'd0, 4'd8);
        @(negedge CLK);
        bus32.in_valid = 1'b0;
        n_checks++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 4'd7) $display("FAIL rst_pre: got v=%b tag=%h want v=1 tag=7", bus32.out_valid, bus32.out_tag); else n_pass++;
        #2 NRES = 1'b0;
        #1;
        n_checks++; if (bus32.out_valid !== 1'b0 || busy32 !== 1'b0) $display("FAIL rst_mid_valid: got v=%b busy=%b want 0 0", bus32.out_valid, busy32); else n_pass++;
        n_checks++; if (bus32.out_result !== 32'h0 || bus32.out_flags !== 4'h0 || bus32.out_tag !== 4'h0) $display("FAIL rst_mid_data: got res=%h fl=%b tag=%h want 0", bus32.out_result, bus32.out_flags, bus32.out_tag); else n_pass++;
        @(negedge CLK);
        NRES = 1'b1;
        bus32.out_ready = 1'b1;
        @(negedge CLK);
        drive32(6'd0, 32'd2, 32'd3, 4'd4);
        @(negedge CLK);
        bus32.in_valid = 1'b0;
        n_checks++; if (bus32.out_valid !== 1'b0) $display("FAIL rst_after_early: got %b want 0", bus32.out_valid); else n_pass++;
        @(negedge CLK);
        n_checks++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 4'd4 || bus32.out_result !== 32'd5 || bus32.out_flags !== 4'b0000) $display("FAIL rst_after: got v=%b tag=%h res=%h fl=%b want v=1 tag=4 res=5 fl=0000", bus32.out_valid, bus32.out_tag, bus32.out_result, bus32.out_flags); else n_pass++;
        @(negedge CLK);
        n_checks++; if (bus32.out_valid !== 1'b0) $display("FAIL rst_no_dup: got %b want 0", bus32.out_valid); else n_pass++;
    endtask

    task automatic test_width8();
        logic [5:0] op8[3];
        logic [7:0] a8[3];
        logic [7:0] b8[3];
        logic [7:0] r8[3];
        logic [3:0] f8[3];
        op8[0] = 6'd8; a8[0] = 8'h80; b8[0] = 8'h01; r8[0] = 8'h01; f8[0] = 4'b0000;
        op8[1] = 6'd9; a8[1] = 8'h80; b8[1] = 8'h01; r8[1] = 8'h00; f8[1] = 4'b0100;
        op8[2] = 6'd0; a8[2] = 8'h7F; b8[2] = 8'h01; r8[2] = 8'h80; f8[2] = 4'b1001;
        bus8.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            bus8.in_valid = 1'b1; bus8.in_opcode = op8[i]; bus8.in_a = a8[i];
            bus8.in_b = b8[i]; bus8.in_tag = 4'(i + 1);
            @(negedge CLK);
            bus8.in_valid = 1'b0;
            @(negedge CLK);
            n_checks++; if (bus8.out_valid !== 1'b1 || bus8.out_tag !== 4'(i + 1)) $display("FAIL w8_%0d_valid: got v=%b tag=%h want v=1 tag=%0d", i, bus8.out_valid, bus8.out_tag, i + 1); else n_pass++;
            n_checks++; if (bus8.out_result !== r8[i]) $display("FAIL w8_%0d_result: got %h want %h", i, bus8.out_result, r8[i]); else n_pass++;
            n_checks++; if (bus8.out_flags !== f8[i]) $display("FAIL w8_%0d_flags: got %b want %b", i, bus8.out_flags, f8[i]); else n_pass++;
        end
        @(negedge CLK);
        n_checks++; if (busy8 !== 1'b0) $display("FAIL w8_busy: got %b want 0", busy8); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ops();
        test_backpressure();
        test_flush();
        test_reset_midstream();
        test_width8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tweak_alu_pipe.md
# tweak_alu_pipe

Parametrised, two-stage pipelined successor to the single-register ALU. It accepts operand/opcode beats over a valid/ready handshake and returns result, condition flags and a caller tag with full throughput and backpressure. Operand width is configurable, and the opcode set adds shifts and compares to the existing add/sub/and/or/xor. It sits between the register-read stage and the writeback stage of the CPU.

## Interface
- WIDTH, 32, operand/result width; must be a power of two, at least 8.
- TAGW, 4, width of the opaque tag carried alongside each operation.
- CLK  in  1  single clock; every element is rising-edge triggered.
- NRES  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous; discards all in-flight operations.
- in_valid  in  1  an input beat is presented.
- in_ready  out  1  the block can accept the presented beat.
- in_opcode  in  6  operation code.
- in_a, in_b  in  WIDTH each  operands.
- in_tag  in  TAGW  carried unchanged to out_tag.
- out_valid  out  1  a result beat is presented.
- out_ready  in  1  the consumer accepts the result beat.
- out_result  out  WIDTH  result.
- out_flags  out  4  {N,Z,C,V}.
- out_tag  out  TAGW  tag of the operation whose result is presented.
- busy  out  1  at least one stage holds a valid operation.

## Operation
- Opcodes:
  - 0 add; 1 sub (a-b); 2 and; 3 or; 4 xor.
  - 5 shl, 6 shr (logical), 7 sar (arithmetic).
  - 8 slt (signed a<b gives 1, else 0); 9 sltu (unsigned).
  - Every other opcode passes a through unchanged.
- Shift amount is b[log2(WIDTH)-1:0]. Higher bits of b are ignored.
- Result is always truncated to WIDTH bits.
- Flags:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C:
    - add: carry out.
    - sub: borrow, i.e. unsigned a<b.
    - shifts: last bit shifted out; 0 when the shift amount is 0.
    - all other opcodes: 0.
  - V: signed overflow for add and sub; 0 for all other opcodes.
- Stage 1 (S1) registers opcode, a, b and tag on acceptance.
- Stage 2 (S2) registers the computed result, flags and tag.
- Advance rules:
  - s2_adv = s1_v & (~s2_v | out_ready).
  - in_ready = ~flush & (~s1_v | s2_adv).
- Transfers:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
- Results emerge strictly in acceptance order. None are dropped or duplicated.
- While out_valid=1 and out_ready=0, out_result, out_flags and out_tag hold stable.
- Flush:
  - Clears s1_v and s2_v at the next edge.
  - in_ready=0 during flush, so a simultaneous in_valid is not accepted.
  - out_valid may be high in the flush cycle. A handshake completing in that cycle still counts as delivered.
- busy = s1_v | s2_v.

## Timing
- Reset, asynchronous on NRES low, takes effect immediately:
  - s1_v, s2_v, out_valid, busy go to 0.
  - out_result, out_flags, out_tag go to 0.
  - in_ready = 1 once NRES is high and flush is low.
- Reset mid-operation drops in-flight beats without producing output.
- Latency: a beat accepted at edge k gives out_valid=1 after edge k+1, provided S2 was empty or drained.
- Throughput is one beat per cycle while out_ready=1.
- in_ready depends combinationally on out_ready. This is the only combinational in-to-out path; there is no combinational path from in_* data to out_*.
- With out_ready held low, capacity is two beats. in_ready falls in the cycle after the second beat is accepted.
- When out_ready rises with both stages full:
  - The S2 beat is consumed.
  - S1 moves to S2 on the same edge.
  - in_ready is 1 during that cycle.

## Test plan
- Add 0xFFFFFFFF + 0x00000001, tag 3 → out_result 0x00000000, flags N0 Z1 C1 V0, out_tag 3; out_valid 2 edges after acceptance.
- Sub 0x80000000 - 0x00000001 → 0x7FFFFFFF, N0 Z0 C0 V1. Sub 0x1 - 0x2 → 0xFFFFFFFF, N1 C1 V0.
- Shifts and pass-through:
  - Sar 0x80000000 by 4 → 0xF8000000, N1 C0.
  - Shl 0x80000001 by b=0x21 (amount 1) → 0x00000002, C1.
  - Opcode 0x3F with a=0x1234 → 0x1234.
- Backpressure: out_ready low, stream tags 1, 2, 3 back-to-back. Tags 1 and 2 are accepted and in_ready drops. Tag-1 outputs stay stable for 5 cycles. Raising out_ready delivers 1, 2, 3 on consecutive cycles with no gaps.
- Flush and reset: with both stages full, assert flush together with in_valid (tag 9). Next cycle out_valid=0, busy=0, tag 9 never appears. Repeat with NRES pulsed low mid-stream: outputs go to 0 immediately and the next accepted beat behaves normally.
- WIDTH=8 instance: slt 0x80, 0x01 → 0x01; sltu 0x80, 0x01 → 0x00; add 0x7F + 0x01 → 0x80, N1 V1 C0.
